// File: rtl/elgamal_pkg.sv
// Shared types and sizing for the ElGamal ephemeral-key path.
package elgamal_pkg;

    localparam int KEY_WIDTH = 64;
    localparam int TRY_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT_RND,
        CHECK,
        GCD,
        DONE,
        FAIL
    } state_t;

endpackage

// File: rtl/binary_gcd_step.sv
// One step of the binary GCD on (a, b) with a held odd; done when b reaches zero,
// at which point a holds the gcd.
module binary_gcd_step
    import elgamal_pkg::*;
#(
    parameter int WIDTH = KEY_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] a_nxt,
    output logic [WIDTH-1:0] b_nxt,
    output logic             done,
    output logic             coprime
);

    always_comb begin
        a_nxt   = a;
        b_nxt   = b;
        done    = (b == '0);
        coprime = (a == WIDTH'(1));
        if (!done) begin
            if (!b[0]) begin
                b_nxt = b >> 1;
            end else if (a > b) begin
                a_nxt = b;
                b_nxt = a;
            end else begin
                b_nxt = b - a;
            end
        end
    end

endmodule

// File: rtl/ephemeral_key_select.sv
// Rejection-samples LFSR words into an ElGamal ephemeral key 1 <= k <= p-2,
// optionally also requiring gcd(k, p-1) = 1, and hands it out on valid/ready.
//
//  state    | meaning
//  IDLE     | waiting for a request; p captured on input_tvalid
//  SETUP    | derive p-1 and its bit mask, clear try counter
//  WAIT_RND | wait for a fresh random word (never the same word twice)
//  CHECK    | range / parity check of the masked candidate
//  GCD      | iterative binary gcd(cand, p-1)
//  DONE     | k valid, waiting for output_tready
//  FAIL     | no key (too many rejects or p < 5), waiting for output_tready
module ephemeral_key_select
    import elgamal_pkg::*;
#(
    parameter int WIDTH         = KEY_WIDTH,
    parameter int COPRIME_CHECK = 1,
    parameter int MAX_TRIES     = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             input_tvalid,
    input  logic [WIDTH-1:0] p,
    input  logic             rnd_tvalid,
    input  logic [WIDTH-1:0] rnd,
    output logic             output_tvalid,
    input  logic             output_tready,
    output logic [WIDTH-1:0] k,
    output logic             fail,
    output logic             busy
);

    localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);

    state_t           state;
    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] pm1;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] last_rnd;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             have_last;
    logic [TRY_W-1:0] try_cnt;

    logic [WIDTH-1:0] pm1_c;
    logic [WIDTH-1:0] mask_c;
    logic [TRY_W-1:0] try_nxt;
    logic [WIDTH-1:0] gcd_a_nxt;
    logic [WIDTH-1:0] gcd_b_nxt;
    logic             gcd_done;
    logic             gcd_coprime;
    logic             cand_ok;
    logic             take;
    logic             rejecting;

    binary_gcd_step #(.WIDTH(WIDTH)) u_gcd (
        .a       (a),
        .b       (b),
        .a_nxt   (gcd_a_nxt),
        .b_nxt   (gcd_b_nxt),
        .done    (gcd_done),
        .coprime (gcd_coprime)
    );

    // Smear the MSB of p-1 downwards to get the sampling mask.
    always_comb begin
        pm1_c  = p_r - WIDTH'(1);
        mask_c = pm1_c;
        for (int s = 1; s < WIDTH; s = s * 2) begin
            mask_c = mask_c | (mask_c >> s);
        end
    end

    // An even candidate shares the factor 2 with the even p-1, so it is dropped before the GCD.
    assign cand_ok = (cand != '0) && (cand < pm1) && !((COPRIME_CHECK != 0) && !cand[0]);
    assign take    = rnd_tvalid && (!have_last || (rnd != last_rnd));
    assign try_nxt = try_cnt + TRY_W'(1);
    assign busy    = (state != IDLE);

    always_comb begin
        rejecting = 1'b0;
        if (state == CHECK) begin
            rejecting = !cand_ok;
        end else if (state == GCD) begin
            rejecting = gcd_done && !gcd_coprime;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            output_tvalid <= 1'b0;
            k             <= '0;
            fail          <= 1'b0;
            try_cnt       <= '0;
            have_last     <= 1'b0;
            p_r           <= '0;
            pm1           <= '0;
            mask          <= '0;
            last_rnd      <= '0;
            cand          <= '0;
            a             <= '0;
            b             <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (input_tvalid) begin
                        p_r   <= p;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    pm1       <= pm1_c;
                    mask      <= mask_c;
                    try_cnt   <= '0;
                    have_last <= 1'b0;
                    if (p_r < WIDTH'(5)) begin
                        state         <= FAIL;
                        output_tvalid <= 1'b1;
                        fail          <= 1'b1;
                        k             <= '0;
                    end else begin
                        state <= WAIT_RND;
                    end
                end
                WAIT_RND: begin
                    if (take) begin
                        last_rnd  <= rnd;
                        have_last <= 1'b1;
                        cand      <= rnd & mask;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (cand_ok) begin
                        if (COPRIME_CHECK != 0) begin
                            a     <= cand;
                            b     <= pm1;
                            state <= GCD;
                        end else begin
                            k             <= cand;
                            output_tvalid <= 1'b1;
                            fail          <= 1'b0;
                            state         <= DONE;
                        end
                    end
                end
                GCD: begin
                    if (!gcd_done) begin
                        a <= gcd_a_nxt;
                        b <= gcd_b_nxt;
                    end else if (gcd_coprime) begin
                        k             <= cand;
                        output_tvalid <= 1'b1;
                        fail          <= 1'b0;
                        state         <= DONE;
                    end
                end
                DONE, FAIL: begin
                    if (output_tready) begin
                        output_tvalid <= 1'b0;
                        fail          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A rejected candidate from CHECK or GCD either retries or gives up.
            if (rejecting) begin
                try_cnt <= try_nxt;
                if (try_nxt == TRY_LIMIT) begin
                    state         <= FAIL;
                    output_tvalid <= 1'b1;
                    fail          <= 1'b1;
                    k             <= '0;
                end else begin
                    state <= WAIT_RND;
                end
            end
        end
    end

endmodule
